// File: rtl/fifo_wr_arb_ctrl_if.sv
// rtl/fifo_wr_arb_ctrl_if.sv - requester, consumer and storage-port signals of the FIFO controller
// master is the requester/consumer side, slave is the controller.
interface fifo_wr_arb_ctrl_if #(
   parameter int ADDR_W = 4,
   parameter int DATA_W = 8
);
   logic              req0_valid;
   logic [DATA_W-1:0] req0_data;
   logic              req0_ready;
   logic              req1_valid;
   logic [DATA_W-1:0] req1_data;
   logic              req1_ready;
   logic              rd_req;
   logic              rd_valid;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_waddr;
   logic [DATA_W-1:0] mem_wdata;
   logic              mem_re;
   logic [ADDR_W-1:0] mem_raddr;

   modport master (
      output req0_valid, req0_data, req1_valid, req1_data, rd_req,
      input  req0_ready, req1_ready, rd_valid,
      input  mem_we, mem_waddr, mem_wdata, mem_re, mem_raddr
   );

   modport slave (
      input  req0_valid, req0_data, req1_valid, req1_data, rd_req,
      output req0_ready, req1_ready, rd_valid,
      output mem_we, mem_waddr, mem_wdata, mem_re, mem_raddr
   );
endinterface

// File: rtl/fifo_wr_arb_ctrl.sv
// rtl/fifo_wr_arb_ctrl.sv - pointer controller and round-robin write arbiter for the 16x8 FIFO
// Owns both pointers, merges two writers onto one storage port, sequences flush and drain.
module fifo_wr_arb_ctrl #(
   parameter int ADDR_W = 4,
   parameter int DATA_W = 8
) (
   input  logic              clock,
   input  logic              reset,
   fifo_wr_arb_ctrl_if.slave bus,
   input  logic              flush,
   input  logic              drain,
   output logic              full,
   output logic              empty,
   output logic [ADDR_W:0]   count,
   output logic              busy,
   output logic              drain_done,
   output logic              rd_err
);
   typedef enum logic [1:0] {
      ST_INIT  = 2'd0,
      ST_RUN   = 2'd1,
      ST_FLUSH = 2'd2,
      ST_DRAIN = 2'd3
   } state_t;

   localparam logic [ADDR_W:0] PTR_ONE = {{ADDR_W{1'b0}}, 1'b1};

   state_t          state;
   logic [ADDR_W:0] wr_ptr;
   logic [ADDR_W:0] rd_ptr;
   logic            last_grant;
   logic            rd_valid_q;

   logic wr_open;
   logic grant0;
   logic grant1;
   logic wr_fire;
   logic rd_window;
   logic rd_fire;
   logic rd_under;

   // Extra pointer bit distinguishes a full array from an empty one.
   assign empty = (wr_ptr == rd_ptr);
   assign full  = (wr_ptr[ADDR_W] != rd_ptr[ADDR_W]) &&
                  (wr_ptr[ADDR_W-1:0] == rd_ptr[ADDR_W-1:0]);
   assign count = wr_ptr - rd_ptr;

   // last_grant names the previous winner, so on contention the other side wins.
   assign wr_open = (state == ST_RUN) && !full;
   assign grant0  = wr_open && bus.req0_valid && (!bus.req1_valid || last_grant);
   assign grant1  = wr_open && bus.req1_valid && (!bus.req0_valid || !last_grant);
   assign wr_fire = grant0 || grant1;

   assign rd_window = (state == ST_RUN) || (state == ST_DRAIN);
   assign rd_fire   = rd_window && bus.rd_req && !empty;
   assign rd_under  = rd_window && bus.rd_req && empty;

   assign bus.req0_ready = grant0;
   assign bus.req1_ready = grant1;
   assign bus.mem_we     = wr_fire;
   assign bus.mem_waddr  = wr_ptr[ADDR_W-1:0];
   assign bus.mem_wdata  = grant0 ? bus.req0_data :
                           grant1 ? bus.req1_data : '0;
   assign bus.mem_re     = rd_fire;
   assign bus.mem_raddr  = rd_ptr[ADDR_W-1:0];
   assign bus.rd_valid   = rd_valid_q;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state      <= ST_INIT;
         busy       <= 1'b1;
         drain_done <= 1'b0;
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         last_grant <= 1'b1;
         rd_valid_q <= 1'b0;
         rd_err     <= 1'b0;
      end else begin
         rd_valid_q <= rd_fire;
         drain_done <= 1'b0;

         if (wr_fire) begin
            wr_ptr     <= wr_ptr + PTR_ONE;
            last_grant <= grant1;
         end
         if (rd_fire) begin
            rd_ptr <= rd_ptr + PTR_ONE;
         end
         if (rd_under) begin
            rd_err <= 1'b1;
         end

         case (state)
            ST_INIT: begin
               state <= ST_RUN;
               busy  <= 1'b0;
            end
            ST_RUN: begin
               if (flush) begin
                  state <= ST_FLUSH;
                  busy  <= 1'b1;
               end else if (drain) begin
                  state <= ST_DRAIN;
                  busy  <= 1'b1;
               end
            end
            ST_FLUSH: begin
               // Nothing moves during FLUSH, so zeroing here cannot lose a transfer.
               wr_ptr <= '0;
               rd_ptr <= '0;
               rd_err <= 1'b0;
               state  <= ST_RUN;
               busy   <= 1'b0;
            end
            ST_DRAIN: begin
               if (flush) begin
                  state <= ST_FLUSH;
               end else if (empty) begin
                  state      <= ST_RUN;
                  busy       <= 1'b0;
                  drain_done <= 1'b1;
               end
            end
            default: begin
               state <= ST_INIT;
               busy  <= 1'b1;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_fifo_wr_arb_ctrl.sv
// tb/tb_fifo_wr_arb_ctrl.sv - directed and random checks of fifo_wr_arb_ctrl against a queue model
module tb_fifo_wr_arb_ctrl;
   localparam int AW    = 4;
   localparam int DW    = 8;
   localparam int DEPTH = 16;

   localparam int MD_INIT  = 0;
   localparam int MD_RUN   = 1;
   localparam int MD_FLUSH = 2;
   localparam int MD_DRAIN = 3;

   logic          clock = 1'b0;
   logic          reset = 1'b1;
   logic          flush = 1'b0;
   logic          drain = 1'b0;
   logic          full;
   logic          empty;
   logic [AW:0]   count;
   logic          busy;
   logic          drain_done;
   logic          rd_err;

   fifo_wr_arb_ctrl_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

   fifo_wr_arb_ctrl #(.ADDR_W(AW), .DATA_W(DW)) dut (
      .clock      (clock),
      .reset      (reset),
      .bus        (bus),
      .flush      (flush),
      .drain      (drain),
      .full       (full),
      .empty      (empty),
      .count      (count),
      .busy       (busy),
      .drain_done (drain_done),
      .rd_err     (rd_err)
   );

   always #5 clock = ~clock;

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model: stored words as a queue, addresses as plain counters.
   int q[$];
   int wa;
   int ra;
   int last_w;
   int mode;
   bit err_m;
   bit rv_m;
   bit dd_m;
   int win;
   bit rd_ok_m;
   int dd_obs;

   task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      q.delete();
      wa     = 0;
      ra     = 0;
      last_w = 1;
      mode   = MD_INIT;
      err_m  = 0;
      rv_m   = 0;
      dd_m   = 0;
   endtask

   task automatic predict();
      bit fullm;
      bit emptym;
      fullm  = (q.size() == DEPTH);
      emptym = (q.size() == 0);
      win = -1;
      if (mode == MD_RUN && !fullm) begin
         if (bus.req0_valid && bus.req1_valid) win = (last_w == 0) ? 1 : 0;
         else if (bus.req0_valid)              win = 0;
         else if (bus.req1_valid)              win = 1;
      end
      rd_ok_m = (mode == MD_RUN || mode == MD_DRAIN) && bus.rd_req && !emptym;
   endtask

   task automatic compare();
      logic [DW-1:0] exp_data;
      predict();
      exp_data = (win == 0) ? bus.req0_data : (win == 1) ? bus.req1_data : '0;
      check("req0_ready", bus.req0_ready, (win == 0));
      check("req1_ready", bus.req1_ready, (win == 1));
      check("mem_we",     bus.mem_we,     (win >= 0));
      check("mem_waddr",  bus.mem_waddr,  wa);
      check("mem_wdata",  bus.mem_wdata,  exp_data);
      check("mem_re",     bus.mem_re,     rd_ok_m);
      check("mem_raddr",  bus.mem_raddr,  ra);
      check("count",      count,          q.size());
      check("full",       full,           (q.size() == DEPTH));
      check("empty",      empty,          (q.size() == 0));
      check("busy",       busy,           (mode != MD_RUN));
      check("rd_valid",   bus.rd_valid,   rv_m);
      check("rd_err",     rd_err,         err_m);
      check("drain_done", drain_done,     dd_m);
      if (drain_done === 1'b1) dd_obs++;
   endtask

   task automatic advance();
      bit was_empty;
      bit under;
      was_empty = (q.size() == 0);
      under = (mode == MD_RUN || mode == MD_DRAIN) && bus.rd_req && was_empty;
      rv_m = rd_ok_m;
      dd_m = 0;
      if (rd_ok_m) begin
         void'(q.pop_front());
         ra = (ra + 1) % DEPTH;
      end
      if (win >= 0) begin
         q.push_back((win == 0) ? int'(bus.req0_data) : int'(bus.req1_data));
         wa     = (wa + 1) % DEPTH;
         last_w = win;
      end
      if (under) err_m = 1;
      case (mode)
         MD_INIT: mode = MD_RUN;
         MD_RUN: begin
            if (flush)      mode = MD_FLUSH;
            else if (drain) mode = MD_DRAIN;
         end
         MD_FLUSH: begin
            q.delete();
            wa    = 0;
            ra    = 0;
            err_m = 0;
            mode  = MD_RUN;
         end
         default: begin
            if (flush) mode = MD_FLUSH;
            else if (was_empty) begin
               mode = MD_RUN;
               dd_m = 1;
            end
         end
      endcase
   endtask

   task automatic tick();
      #1;
      compare();
      advance();
      @(negedge clock);
   endtask

   task automatic clear_inputs();
      bus.req0_valid = 1'b0;
      bus.req0_data  = '0;
      bus.req1_valid = 1'b0;
      bus.req1_data  = '0;
      bus.rd_req     = 1'b0;
      flush          = 1'b0;
      drain          = 1'b0;
   endtask

   task automatic do_reset();
      clear_inputs();
      reset = 1'b1;
      model_reset();
      #1;
      compare();
      @(negedge clock);
      reset = 1'b0;
   endtask

   task automatic load_words(int target);
      bus.req1_valid = 1'b0;
      bus.rd_req     = 1'b0;
      bus.req0_valid = 1'b1;
      for (int i = 0; i < 40 && q.size() < target; i++) begin
         bus.req0_data = 8'($urandom);
         tick();
      end
      bus.req0_valid = 1'b0;
      check("load_level", count, target);
   endtask

   initial begin
      int k;
      int n0;
      int n1;
      clear_inputs();
      model_reset();

      // Reset state, then a single writer filling the array from 0x11 to 0x20.
      @(negedge clock);
      #1;
      compare();
      @(negedge clock);
      reset = 1'b0;
      k = 0;
      bus.req0_valid = 1'b1;
      bus.req0_data  = 8'h11;
      for (int i = 0; i < 18; i++) begin
         tick();
         if (win == 0) begin
            k++;
            bus.req0_data = 8'(8'h11 + k);
         end
      end
      check("fill_count", count, 16);
      check("fill_full",  full,  1);
      check("fill_words", k,     16);

      // Contention from a fresh reset: grants alternate starting with requester 0.
      do_reset();
      n0 = 0;
      n1 = 0;
      bus.req0_valid = 1'b1;
      bus.req1_valid = 1'b1;
      bus.req0_data  = 8'hA0;
      bus.req1_data  = 8'hB0;
      for (int i = 0; i < 9; i++) begin
         tick();
         if (win == 0) n0++;
         if (win == 1) n1++;
         bus.req0_data = 8'(8'hA0 + n0);
         bus.req1_data = 8'(8'hB0 + n1);
      end
      check("alt_wins0", n0, 4);
      check("alt_wins1", n1, 4);

      // Full array with reads and a waiting writer: pointers wrap, count stays 15..16.
      do_reset();
      load_words(16);
      bus.rd_req     = 1'b1;
      bus.req1_valid = 1'b1;
      for (int i = 0; i < 20; i++) begin
         bus.req1_data = 8'($urandom);
         tick();
         #1;
         check("wrap_range", (count >= 15 && count <= 16), 1);
      end
      clear_inputs();

      // Underflow sets the sticky error; flush clears it and empties the array.
      flush = 1'b1;
      tick();
      flush = 1'b0;
      tick();
      bus.rd_req = 1'b1;
      for (int i = 0; i < 3; i++) tick();
      bus.rd_req = 1'b0;
      for (int i = 0; i < 2; i++) tick();
      #1;
      check("err_sticky", rd_err, 1);
      flush = 1'b1;
      tick();
      flush = 1'b0;
      for (int i = 0; i < 2; i++) tick();
      #1;
      check("flush_err", rd_err, 0);
      check("flush_empty", empty, 1);

      // Drain with five stored words while a writer waits.
      load_words(5);
      dd_obs = 0;
      drain      = 1'b1;
      bus.rd_req = 1'b1;
      tick();
      drain = 1'b0;
      bus.req0_valid = 1'b1;
      for (int i = 0; i < 12; i++) begin
         bus.req0_data = 8'($urandom);
         tick();
      end
      check("drain_pulses", dd_obs, 1);
      clear_inputs();

      // Reset asserted mid-drain acts without a clock edge and drops rd_valid.
      do_reset();
      load_words(4);
      drain      = 1'b1;
      bus.rd_req = 1'b1;
      tick();
      clear_inputs();
      #1;
      check("pre_count",    count,        3);
      check("pre_rd_valid", bus.rd_valid, 1);
      check("pre_busy",     busy,         1);
      #1;
      reset = 1'b1;
      #1;
      check("rst_full",     full,         0);
      check("rst_empty",    empty,        1);
      check("rst_count",    count,        0);
      check("rst_busy",     busy,         1);
      check("rst_rd_valid", bus.rd_valid, 0);
      model_reset();
      @(negedge clock);
      reset = 1'b0;

      // Random traffic with occasional flush and drain.
      for (int i = 0; i < 400; i++) begin
         bus.req0_valid = 1'($urandom_range(0, 1));
         bus.req1_valid = 1'($urandom_range(0, 1));
         bus.req0_data  = 8'($urandom);
         bus.req1_data  = 8'($urandom);
         bus.rd_req     = ($urandom_range(0, 2) == 0);
         flush          = ($urandom_range(0, 39) == 0);
         drain          = ($urandom_range(0, 29) == 0);
         tick();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end
endmodule
